// File: rtl/ex_wb_buf_if.sv
// Handshake and data bundle between the execute stage, the result buffer
// and the register-file write port.
interface ex_wb_buf_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [0:127]      in_res;
  logic [0:ADDR_W-1] in_addr;
  logic [0:2]        in_ppp;
  logic [0:1]        in_ww;
  logic              rf_we;
  logic              rf_ready;
  logic [0:ADDR_W-1] rf_addr;
  logic [0:127]      rf_data;
  logic [0:15]       rf_bmask;

  // Environment side: produces results, consumes register-file writes.
  modport master (
    output in_valid, in_res, in_addr, in_ppp, in_ww, rf_ready,
    input  in_ready, rf_we, rf_addr, rf_data, rf_bmask
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_res, in_addr, in_ppp, in_ww, rf_ready,
    output in_ready, rf_we, rf_addr, rf_data, rf_bmask
  );
endinterface

// File: rtl/ex_wb_buf.sv
// Two-entry in-order result buffer between execute and register-file write.
// The byte-enable mask is resolved from participation/element width when the
// result is accepted, so the write side only carries a ready-made mask.
module ex_wb_buf #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  ex_wb_buf_if.slave  bus,
  output logic [0:1]  count
);

  localparam logic [0:1] FULL = 2'(DEPTH);

  logic [0:127]      res_q  [0:1];
  logic [0:ADDR_W-1] addr_q [0:1];
  logic [0:15]       mask_q [0:1];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  // Byte enables, bit 0 covering the most significant byte of the result.
  function automatic logic [0:15] calc_mask(input logic [0:2] ppp,
                                            input logic [0:1] ww);
    logic [0:15] m;
    m = 16'h0000;
    case (ppp)
      3'b000: m = 16'hFFFF;
      3'b001: m = 16'hFF00;
      3'b010: m = 16'h00FF;
      3'b011: begin
        case (ww)
          2'b00:   m = 16'hAAAA;
          2'b01:   m = 16'hCCCC;
          2'b10:   m = 16'hF0F0;
          default: m = 16'hFF00;
        endcase
      end
      3'b100: begin
        case (ww)
          2'b00:   m = 16'h5555;
          2'b01:   m = 16'h3333;
          2'b10:   m = 16'h0F0F;
          default: m = 16'h00FF;
        endcase
      end
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Handshakes; acceptance is independent of the write side so a full buffer
  // never relies on a same-cycle drain.
  always_comb begin
    bus.in_ready = (count != FULL) & rst;
    bus.rf_we    = (count != 2'd0);
    bus.rf_addr  = addr_q[rd_ptr];
    bus.rf_data  = res_q[rd_ptr];
    bus.rf_bmask = mask_q[rd_ptr];
    push         = bus.in_valid & bus.in_ready;
    pop          = bus.rf_we & bus.rf_ready;
  end

  // Storage, pointers and occupancy; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        addr_q[i] <= '0;
        mask_q[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        res_q[wr_ptr]  <= bus.in_res;
        addr_q[wr_ptr] <= bus.in_addr;
        mask_q[wr_ptr] <= calc_mask(bus.in_ppp, bus.in_ww);
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb_buf.sv
module tb_ex_wb_buf;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [127:0]  res;
    logic [0:15]   mask;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:1] dut_count;
  int         errors = 0;
  int         checks = 0;

  entry_t q[$];
  entry_t plog[$];
  entry_t wlog[$];

  ex_wb_buf_if #(.ADDR_W(AW)) bus ();

  ex_wb_buf #(.ADDR_W(AW), .DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (dut_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference mask: each byte is enabled according to which element it
  // falls in, derived from the participation rule rather than a table.
  function automatic logic [0:15] ref_mask(input logic [2:0] ppp, input logic [1:0] ww);
    logic [0:15] m;
    int bpe;
    bpe = 1 << ww;
    for (int i = 0; i < 16; i++) begin
      case (ppp)
        3'd0:    m[i] = 1'b1;
        3'd1:    m[i] = (i < 8);
        3'd2:    m[i] = (i >= 8);
        3'd3:    m[i] = ((i / bpe) % 2 == 0);
        3'd4:    m[i] = ((i / bpe) % 2 == 1);
        default: m[i] = 1'b0;
      endcase
    end
    return m;
  endfunction

  // One clock: drive, check outputs against the model, clock, update model.
  task automatic cycle(input logic v, input logic [127:0] res, input logic [AW-1:0] addr,
                       input logic [2:0] ppp, input logic [1:0] ww, input logic rdy);
    bit push, pop;
    entry_t e;
    bus.in_valid = v;
    bus.in_res   = res;
    bus.in_addr  = addr;
    bus.in_ppp   = ppp;
    bus.in_ww    = ww;
    bus.rf_ready = rdy;
    #1;
    chk("in_ready", bus.in_ready, (rst && q.size() < 2));
    chk("rf_we", bus.rf_we, (q.size() != 0));
    chk("count", dut_count, q.size());
    if (q.size() != 0) begin
      chk("rf_addr", bus.rf_addr, q[0].addr);
      chk("rf_data", bus.rf_data, q[0].res);
      chk("rf_bmask", bus.rf_bmask, q[0].mask);
    end
    push = rst && v && (q.size() < 2);
    pop  = rst && (q.size() != 0) && rdy;
    if (rst && bus.rf_we && rdy) begin
      e.addr = bus.rf_addr; e.res = bus.rf_data; e.mask = bus.rf_bmask;
      wlog.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rst) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.addr = addr; e.res = res; e.mask = ref_mask(ppp, ww);
        q.push_back(e);
        plog.push_back(e);
      end
    end
  endtask

  task automatic chk_cleared();
    chk("clr_count", dut_count, 0);
    chk("clr_rf_we", bus.rf_we, 0);
    chk("clr_rf_addr", bus.rf_addr, 0);
    chk("clr_rf_data", bus.rf_data, 0);
    chk("clr_rf_bmask", bus.rf_bmask, 0);
  endtask

  initial begin
    int n_w;
    int cyc;
    logic [127:0] r;
    bus.in_valid = 0; bus.in_res = '0; bus.in_addr = '0;
    bus.in_ppp = '0; bus.in_ww = '0; bus.rf_ready = 0;

    // Reset
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready_low", bus.in_ready, 0);
    chk_cleared();
    rst = 1'b1;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Single push then write
    r = 128'h000c0006000f00150f000a87fe01fd02;
    cycle(1, r, 5'd3, 3'd0, 2'd0, 1);
    chk("single_head_mask", bus.rf_bmask, 16'hFFFF);
    cycle(0, '0, 5'd0, 3'd0, 2'd0, 1);
    cycle(0, '0, 5'd0, 3'd0, 2'd0, 1);

    // Fill while blocked, third push held off, then drain
    wlog.delete();
    cycle(1, 128'h11, 5'd1, 3'd0, 2'd0, 0);
    cycle(1, 128'h22, 5'd2, 3'd0, 2'd0, 0);
    cycle(1, 128'h33, 5'd3, 3'd0, 2'd0, 0);
    chk("full_count", dut_count, 2);
    for (int i = 0; i < 3; i++) cycle(0, '0, 5'd0, 3'd0, 2'd0, 1);
    chk("drain_len", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("drain_addr0", wlog[0].addr, 1);
      chk("drain_addr1", wlog[1].addr, 2);
    end

    // Simultaneous push and pop at count 1
    cycle(1, 128'h55, 5'd5, 3'd0, 2'd0, 0);
    cycle(1, 128'h77, 5'd7, 3'd1, 2'd0, 1);
    chk("simul_count", dut_count, 1);
    chk("simul_head", bus.rf_addr, 7);
    cycle(0, '0, 5'd0, 3'd0, 2'd0, 1);

    // Mask sweep
    for (int p = 3; p <= 4; p++)
      for (int w = 0; w < 4; w++) begin
        cycle(1, {$urandom, $urandom, $urandom, $urandom}, 5'(p * 4 + w), 3'(p), 2'(w), 1);
      end
    cycle(1, 128'h1, 5'd9, 3'd1, 2'd2, 1);
    cycle(1, 128'h2, 5'd10, 3'd2, 2'd1, 1);
    cycle(1, 128'h3, 5'd11, 3'd5, 2'd0, 1);
    cycle(0, '0, 5'd0, 3'd0, 2'd0, 0);
    chk("mask_ppp101", bus.rf_bmask, 16'h0000);
    cycle(0, '0, 5'd0, 3'd0, 2'd0, 1);

    // Reset with a full buffer
    cycle(1, 128'haa, 5'd20, 3'd0, 2'd0, 0);
    cycle(1, 128'hbb, 5'd21, 3'd0, 2'd0, 0);
    n_w = wlog.size();
    rst = 1'b0;
    cycle(1, 128'hcc, 5'd22, 3'd0, 2'd0, 1);
    rst = 1'b1;
    chk_cleared();
    cycle(0, '0, 5'd0, 3'd0, 2'd0, 1);
    cycle(0, '0, 5'd0, 3'd0, 2'd0, 1);
    chk("rst_no_writes", wlog.size(), n_w);

    // Random traffic
    wlog.delete();
    plog.delete();
    cyc = 0;
    while (plog.size() < 100 && cyc < 3000) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
            5'($urandom), 3'($urandom_range(0, 7)), 2'($urandom), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_push_budget", plog.size(), 100);
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      cycle(0, '0, 5'd0, 3'd0, 2'd0, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_drain_budget", q.size(), 0);
    chk("rand_len", wlog.size(), plog.size());
    for (int i = 0; i < plog.size() && i < wlog.size(); i++) begin
      chk("rand_addr", wlog[i].addr, plog[i].addr);
      chk("rand_data", wlog[i].res, plog[i].res);
      chk("rand_mask", wlog[i].mask, plog[i].mask);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
